// File: rtl/mapper_mem_arbiter.sv
// Shares the cartridge memory port between PPU CHR, CPU PRG and the aux (savestate/loader) port.
// Fixed priority chr > prg > aux, with forced aux grants after STARVE_LIMIT bypasses and a stall watchdog.
module mapper_mem_arbiter #(
  parameter int STARVE_LIMIT = 8,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chr_req,
  input  logic [21:0] chr_addr,
  output logic [7:0]  chr_rdata,
  output logic        chr_done,
  input  logic        prg_req,
  input  logic        prg_we,
  input  logic [21:0] prg_addr,
  input  logic [7:0]  prg_wdata,
  output logic [7:0]  prg_rdata,
  output logic        prg_done,
  input  logic        aux_req,
  input  logic        aux_we,
  input  logic [21:0] aux_addr,
  input  logic [7:0]  aux_wdata,
  output logic [7:0]  aux_rdata,
  output logic        aux_done,
  output logic        mem_req,
  output logic        mem_we,
  output logic [21:0] mem_addr,
  output logic [7:0]  mem_wdata,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic [2:0]  overrun,
  output logic        timeout_err
);

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {G_CHR = 2'd0, G_PRG = 2'd1, G_AUX = 2'd2} gnt_t;

  localparam logic [7:0] STARVE_LIM = 8'(STARVE_LIMIT);
  localparam logic [9:0] WD_LAST    = 10'(TIMEOUT - 1);

  state_t      state;
  gnt_t        gnt;
  gnt_t        sel;
  logic [2:0]  pend;
  logic [7:0]  starve_cnt;
  logic [9:0]  wdog;

  logic [21:0] chr_addr_q;
  logic [21:0] prg_addr_q;
  logic [21:0] aux_addr_q;
  logic        prg_we_q;
  logic        aux_we_q;
  logic [7:0]  prg_wdata_q;
  logic [7:0]  aux_wdata_q;

  logic        finish;
  logic        grant;
  logic [2:0]  req_v;
  logic [2:0]  fin_vec;
  logic [2:0]  accept;
  logic [7:0]  rd;

  always_comb begin
    finish  = (state == WAIT) && (mem_ack || (wdog == WD_LAST));
    grant   = (state == IDLE) && (pend != 3'b000);
    rd      = mem_ack ? mem_rdata : 8'hFF;
    req_v   = {aux_req, prg_req, chr_req};
    fin_vec = {finish && (gnt == G_AUX), finish && (gnt == G_PRG), finish && (gnt == G_CHR)};
    // A request landing on its own completion cycle is accepted: set wins over clear.
    accept  = req_v & (~pend | fin_vec);
    if (pend[2] && (starve_cnt >= STARVE_LIM)) begin
      sel = G_AUX;
    end else if (pend[0]) begin
      sel = G_CHR;
    end else if (pend[1]) begin
      sel = G_PRG;
    end else begin
      sel = G_AUX;
    end
  end

  // Request capture registers: only written when the request is accepted.
  always_ff @(posedge clk) begin
    if (accept[0]) begin
      chr_addr_q <= chr_addr;
    end
    if (accept[1]) begin
      prg_addr_q  <= prg_addr;
      prg_we_q    <= prg_we;
      prg_wdata_q <= prg_wdata;
    end
    if (accept[2]) begin
      aux_addr_q  <= aux_addr;
      aux_we_q    <= aux_we;
      aux_wdata_q <= aux_wdata;
    end
  end

  // Arbitration FSM and registered memory/completion outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      gnt         <= G_CHR;
      pend        <= 3'b000;
      starve_cnt  <= 8'd0;
      wdog        <= 10'd0;
      mem_req     <= 1'b0;
      mem_we      <= 1'b0;
      mem_addr    <= 22'd0;
      mem_wdata   <= 8'd0;
      chr_rdata   <= 8'h00;
      prg_rdata   <= 8'h00;
      aux_rdata   <= 8'h00;
      chr_done    <= 1'b0;
      prg_done    <= 1'b0;
      aux_done    <= 1'b0;
      overrun     <= 3'b000;
      timeout_err <= 1'b0;
    end else begin
      chr_done    <= 1'b0;
      prg_done    <= 1'b0;
      aux_done    <= 1'b0;
      timeout_err <= 1'b0;
      pend        <= (pend & ~fin_vec) | accept;
      overrun     <= overrun | (req_v & ~accept);

      case (state)
        IDLE: begin
          if (grant) begin
            state   <= WAIT;
            gnt     <= sel;
            mem_req <= 1'b1;
            wdog    <= 10'd0;
            case (sel)
              G_CHR: begin
                mem_addr  <= chr_addr_q;
                mem_we    <= 1'b0;
                mem_wdata <= 8'd0;
              end
              G_PRG: begin
                mem_addr  <= prg_addr_q;
                mem_we    <= prg_we_q;
                mem_wdata <= prg_wdata_q;
              end
              default: begin
                mem_addr  <= aux_addr_q;
                mem_we    <= aux_we_q;
                mem_wdata <= aux_wdata_q;
              end
            endcase
          end
        end
        WAIT: begin
          if (finish) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            timeout_err <= !mem_ack;
            case (gnt)
              G_CHR: begin
                chr_rdata <= rd;
                chr_done  <= 1'b1;
              end
              G_PRG: begin
                prg_rdata <= rd;
                prg_done  <= 1'b1;
              end
              default: begin
                aux_rdata <= rd;
                aux_done  <= 1'b1;
              end
            endcase
          end else begin
            wdog <= wdog + 10'd1;
          end
        end
        default: state <= IDLE;
      endcase

      if (!pend[2]) begin
        starve_cnt <= 8'd0;
      end else if (grant) begin
        if (sel == G_AUX) begin
          starve_cnt <= 8'd0;
        end else if (starve_cnt != 8'hFF) begin
          starve_cnt <= starve_cnt + 8'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_mapper_mem_arbiter.sv
// Bench for mapper_mem_arbiter: transaction-level reference model, directed scenarios, then random traffic.
module tb_mapper_mem_arbiter;
  localparam int LIM = 2;
  localparam int TO  = 4;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        chr_req = 1'b0;
  logic [21:0] chr_addr = '0;
  logic        prg_req = 1'b0;
  logic        prg_we = 1'b0;
  logic [21:0] prg_addr = '0;
  logic [7:0]  prg_wdata = '0;
  logic        aux_req = 1'b0;
  logic        aux_we = 1'b0;
  logic [21:0] aux_addr = '0;
  logic [7:0]  aux_wdata = '0;
  logic        mem_ack = 1'b0;
  logic [7:0]  mem_rdata = '0;
  logic [7:0]  chr_rdata, prg_rdata, aux_rdata;
  logic        chr_done, prg_done, aux_done;
  logic        mem_req, mem_we;
  logic [21:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [2:0]  overrun;
  logic        timeout_err;

  always #5 clk = ~clk;

  mapper_mem_arbiter #(.STARVE_LIMIT(LIM), .TIMEOUT(TO)) dut (
    .clk(clk), .reset_n(reset_n),
    .chr_req(chr_req), .chr_addr(chr_addr), .chr_rdata(chr_rdata), .chr_done(chr_done),
    .prg_req(prg_req), .prg_we(prg_we), .prg_addr(prg_addr), .prg_wdata(prg_wdata),
    .prg_rdata(prg_rdata), .prg_done(prg_done),
    .aux_req(aux_req), .aux_we(aux_we), .aux_addr(aux_addr), .aux_wdata(aux_wdata),
    .aux_rdata(aux_rdata), .aux_done(aux_done),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .overrun(overrun), .timeout_err(timeout_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference model: requesters indexed 0=chr, 1=prg, 2=aux.
  logic [2:0]  m_pend;
  logic [21:0] m_addr [3];
  logic        m_we   [3];
  logic [7:0]  m_wd   [3];
  logic        m_busy;
  int          m_g, m_wait, m_starve;
  logic [21:0] e_addr;
  logic        e_we;
  logic [7:0]  e_wd;
  logic [2:0]  e_done;
  logic [7:0]  e_rd [3];
  logic [2:0]  e_ovr;
  logic        e_to;

  // Memory responder controls.
  int   wc = 0;
  int   lat = 99;
  logic rand_mode = 1'b0;
  logic stray_en = 1'b0;
  logic [7:0] ack_data = 8'h00;

  int i, ng, nwait, gap, ndone;
  logic prev, seen, rereq, sent3, sent4;
  logic [21:0] order [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: actual %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_pend = 3'b000; m_busy = 1'b0; m_g = 0; m_wait = 0; m_starve = 0;
    e_addr = '0; e_we = 1'b0; e_wd = '0; e_done = 3'b000; e_ovr = 3'b000; e_to = 1'b0;
    for (int r = 0; r < 3; r++) begin
      e_rd[r] = 8'h00; m_addr[r] = '0; m_we[r] = 1'b0; m_wd[r] = '0;
    end
  endtask

  task automatic model_step();
    logic [2:0] req, was;
    logic fin;
    int g;
    if (!reset_n) begin
      model_reset();
      return;
    end
    req = {aux_req, prg_req, chr_req};
    was = m_pend;
    fin = 1'b0;
    e_done = 3'b000;
    e_to = 1'b0;
    if (m_busy) begin
      if (mem_ack) begin
        fin = 1'b1; e_rd[m_g] = mem_rdata;
      end else if (m_wait >= TO - 1) begin
        fin = 1'b1; e_rd[m_g] = 8'hFF; e_to = 1'b1;
      end else begin
        m_wait++;
      end
      if (fin) begin
        e_done[m_g] = 1'b1; m_busy = 1'b0; m_pend[m_g] = 1'b0;
      end
    end else if (was != 3'b000) begin
      if (was[2] && m_starve >= LIM) g = 2;
      else if (was[0]) g = 0;
      else if (was[1]) g = 1;
      else g = 2;
      m_g = g; m_busy = 1'b1; m_wait = 0;
      e_addr = m_addr[g]; e_we = m_we[g]; e_wd = m_wd[g];
      if (was[2]) m_starve = (g == 2) ? 0 : ((m_starve < 255) ? m_starve + 1 : 255);
    end
    if (!was[2]) m_starve = 0;
    for (int r = 0; r < 3; r++) begin
      if (req[r]) begin
        if (!was[r] || (fin && m_g == r)) begin
          m_pend[r] = 1'b1;
          case (r)
            0: begin m_addr[0] = chr_addr; m_we[0] = 1'b0; m_wd[0] = 8'h00; end
            1: begin m_addr[1] = prg_addr; m_we[1] = prg_we; m_wd[1] = prg_wdata; end
            default: begin m_addr[2] = aux_addr; m_we[2] = aux_we; m_wd[2] = aux_wdata; end
          endcase
        end else begin
          e_ovr[r] = 1'b1;
        end
      end
    end
  endtask

  task automatic compare_all();
    chk("mem_req",     32'(mem_req),     32'(m_busy));
    chk("mem_addr",    32'(mem_addr),    32'(e_addr));
    chk("mem_we",      32'(mem_we),      32'(e_we));
    chk("mem_wdata",   32'(mem_wdata),   32'(e_wd));
    chk("chr_done",    32'(chr_done),    32'(e_done[0]));
    chk("prg_done",    32'(prg_done),    32'(e_done[1]));
    chk("aux_done",    32'(aux_done),    32'(e_done[2]));
    chk("chr_rdata",   32'(chr_rdata),   32'(e_rd[0]));
    chk("prg_rdata",   32'(prg_rdata),   32'(e_rd[1]));
    chk("aux_rdata",   32'(aux_rdata),   32'(e_rd[2]));
    chk("overrun",     32'(overrun),     32'(e_ovr));
    chk("timeout_err", 32'(timeout_err), 32'(e_to));
  endtask

  task automatic respond();
    if (m_busy) begin
      if (wc == 0 && rand_mode) lat = $urandom_range(0, 5);
      mem_ack = (wc == lat);
      mem_rdata = rand_mode ? 8'($urandom) : ack_data;
      wc++;
    end else begin
      wc = 0;
      mem_ack = stray_en & ($urandom_range(0, 7) == 0);
      mem_rdata = 8'($urandom);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    compare_all();
    chr_req = 1'b0; prg_req = 1'b0; aux_req = 1'b0;
    respond();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  initial begin
    model_reset();
    repeat (3) tick();
    chk("rst_mem_req",   32'(mem_req),   32'h0);
    chk("rst_mem_addr",  32'(mem_addr),  32'h0);
    chk("rst_overrun",   32'(overrun),   32'h0);
    chk("rst_chr_rdata", 32'(chr_rdata), 32'h0);
    chk("rst_dones",     32'({chr_done, prg_done, aux_done}), 32'h0);
    reset_n = 1'b1;
    repeat (2) tick();

    // Single CHR read, ack 3 cycles after mem_req.
    lat = 3; ack_data = 8'hA5;
    chr_addr = 22'h201FD8; chr_req = 1'b1;
    seen = 1'b0; ndone = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (mem_req && !seen) begin
        seen = 1'b1;
        chk("rd_addr", 32'(mem_addr), 32'h201FD8);
        chk("rd_we",   32'(mem_we),   32'h0);
      end
      if (chr_done) begin
        ndone++;
        chk("rd_data",       32'(chr_rdata), 32'hA5);
        chk("rd_other_done", 32'({prg_done, aux_done}), 32'h0);
      end
    end
    chk("rd_seen", 32'(seen), 32'h1);
    chk("rd_done_count", 32'(ndone), 32'h1);

    // Simultaneous requests: grant order chr, prg, aux with one idle cycle between.
    lat = 1; ack_data = 8'h11;
    chr_addr = 22'h000111; chr_req = 1'b1;
    prg_we = 1'b1; prg_addr = 22'h3C0010; prg_wdata = 8'h5A; prg_req = 1'b1;
    aux_we = 1'b0; aux_addr = 22'h155555; aux_req = 1'b1;
    ng = 0; prev = 1'b0; gap = 0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mem_req && !prev) begin
        if (ng < 8) order[ng] = mem_addr;
        if (ng > 0) chk("prio_gap", 32'(gap), 32'h1);
        if (mem_addr == 22'h3C0010) begin
          chk("prio_we",    32'(mem_we),    32'h1);
          chk("prio_wdata", 32'(mem_wdata), 32'h5A);
        end
        ng++;
      end
      gap = mem_req ? 0 : gap + 1;
      prev = mem_req;
    end
    chk("prio_ngrant", 32'(ng), 32'h3);
    chk("prio_first",  32'(order[0]), 32'h000111);
    chk("prio_second", 32'(order[1]), 32'h3C0010);
    chk("prio_third",  32'(order[2]), 32'h155555);

    // Starvation: chr and prg keep re-requesting while aux waits.
    lat = 0; ack_data = 8'h22;
    chr_addr = 22'h000100; prg_we = 1'b0; prg_addr = 22'h000200; aux_we = 1'b0; aux_addr = 22'h000300;
    chr_req = 1'b1; prg_req = 1'b1; aux_req = 1'b1;
    rereq = 1'b1; ng = 0; prev = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mem_req && !prev) begin
        if (ng < 8) order[ng] = mem_addr;
        ng++;
        if (mem_addr == 22'h000300) rereq = 1'b0;
      end
      prev = mem_req;
      if (rereq && chr_done) chr_req = 1'b1;
      if (rereq && prg_done) prg_req = 1'b1;
    end
    chk("starve_g0", 32'(order[0]), 32'h000100);
    chk("starve_g1", 32'(order[1]), 32'h000200);
    chk("starve_g2_aux", 32'(order[2]), 32'h000300);
    chk("starve_g3", 32'(order[3]), 32'h000100);

    // Overrun, then requests on the ack cycle and on the done cycle.
    lat = 2; ack_data = 8'h33;
    prg_we = 1'b0; prg_addr = 22'h0A0A01; prg_req = 1'b1;
    tick();
    prg_addr = 22'h0A0A02; prg_req = 1'b1;
    ng = 0; prev = 1'b0; sent3 = 1'b0; sent4 = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      if (mem_req && !prev) begin
        if (ng < 8) order[ng] = mem_addr;
        ng++;
      end
      prev = mem_req;
      if (mem_ack && !sent3) begin
        sent3 = 1'b1; prg_addr = 22'h0A0A03; prg_req = 1'b1;
      end else if (prg_done && sent3 && !sent4 && ng >= 2) begin
        sent4 = 1'b1; prg_addr = 22'h0A0A04; prg_req = 1'b1;
      end
    end
    chk("ovr_ngrant",   32'(ng), 32'h3);
    chk("ovr_first",    32'(order[0]), 32'h0A0A01);
    chk("ovr_ackcycle", 32'(order[1]), 32'h0A0A03);
    chk("ovr_donecyc",  32'(order[2]), 32'h0A0A04);
    chk("ovr_flags",    32'(overrun), 32'h2);

    // Watchdog abort on an aux read that is never acknowledged.
    lat = 99;
    aux_we = 1'b0; aux_addr = 22'h2AAAAA; aux_req = 1'b1;
    nwait = 0; i = 0;
    while (!aux_done && i < 30) begin
      tick();
      if (mem_req) nwait++;
      i++;
    end
    chk("to_seen",        32'(aux_done),    32'h1);
    chk("to_wait_cycles", 32'(nwait),       32'h4);
    chk("to_rdata",       32'(aux_rdata),   32'hFF);
    chk("to_err",         32'(timeout_err), 32'h1);
    chk("to_mem_req",     32'(mem_req),     32'h0);
    tick();
    chk("to_err_pulse", 32'(timeout_err), 32'h0);
    mem_ack = 1'b1; mem_rdata = 8'h5C;
    tick();
    chk("stray_no_done", 32'({chr_done, prg_done, aux_done}), 32'h0);
    chk("stray_no_req",  32'(mem_req), 32'h0);

    // Reset asserted while a write is waiting for ack.
    prg_we = 1'b1; prg_addr = 22'h123456; prg_wdata = 8'hC3; prg_req = 1'b1;
    i = 0;
    while (!mem_req && i < 10) begin
      tick();
      i++;
    end
    chk("rstw_req_seen", 32'(mem_req), 32'h1);
    tick();
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("rstw_async_req",  32'(mem_req),  32'h0);
    chk("rstw_async_addr", 32'(mem_addr), 32'h0);
    compare_all();
    repeat (2) tick();
    reset_n = 1'b1;
    mem_ack = 1'b1; mem_rdata = 8'h77;
    tick();
    chk("rstw_late_ack", 32'({chr_done, prg_done, aux_done}), 32'h0);
    tick();
    chk("rstw_no_pending", 32'(mem_req), 32'h0);
    lat = 1; ack_data = 8'h4E;
    aux_we = 1'b0; aux_addr = 22'h0F0F0F; aux_req = 1'b1;
    i = 0;
    while (!aux_done && i < 20) begin
      tick();
      i++;
    end
    chk("rstw_new_done",  32'(aux_done),  32'h1);
    chk("rstw_new_rdata", 32'(aux_rdata), 32'h4E);

    // Random traffic with random ack latency (including timeouts) and stray acks.
    rand_mode = 1'b1; stray_en = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      chr_req   = ($urandom_range(0, 3) == 0);
      chr_addr  = 22'($urandom);
      prg_req   = ($urandom_range(0, 3) == 0);
      prg_we    = $urandom_range(0, 1) == 1;
      prg_addr  = 22'($urandom);
      prg_wdata = 8'($urandom);
      aux_req   = ($urandom_range(0, 5) == 0);
      aux_we    = $urandom_range(0, 1) == 1;
      aux_addr  = 22'($urandom);
      aux_wdata = 8'($urandom);
      tick();
    end
    repeat (30) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
